// File: rtl/mem_bus_scheduler_if.sv
// Signal bundle for mem_bus_scheduler: three requester ports plus the shared memory bus.
// slave = scheduler side, master = requesters/bus model side.
interface mem_bus_scheduler_if;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [31:0] data_a, data_b, data_c;
  logic        we_a, we_b, we_c;
  logic        start_a, start_b, start_c;
  logic        done_a, done_b, done_c;
  logic [31:0] q;
  logic [26:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we;
  logic        bus_start;
  logic [31:0] bus_q;
  logic        bus_done;
  logic        err_timeout;

  modport slave (
    input  addr_a, addr_b, addr_c, data_a, data_b, data_c,
    input  we_a, we_b, we_c, start_a, start_b, start_c,
    output done_a, done_b, done_c, q,
    output bus_addr, bus_data, bus_we, bus_start,
    input  bus_q, bus_done,
    output err_timeout
  );

  modport master (
    output addr_a, addr_b, addr_c, data_a, data_b, data_c,
    output we_a, we_b, we_c, start_a, start_b, start_c,
    input  done_a, done_b, done_c, q,
    input  bus_addr, bus_data, bus_we, bus_start,
    output bus_q, bus_done,
    input  err_timeout
  );
endinterface

// File: rtl/mem_bus_scheduler.sv
// Three-port memory bus scheduler: fixed priority A>B>C with starvation promotion.
// Optional bus watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_scheduler #(
  parameter int unsigned STARVE_LIMIT = 8
`ifdef MEM_BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input logic                clk,
  input logic                reset,
  mem_bus_scheduler_if.slave mb
);
  localparam int unsigned   WW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B, GNT_C} grant_e;

  state_e        state_q, state_d;
  grant_e        grant_q, grant_d, winner;
  logic [26:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_data_q, bus_data_d;
  logic          bus_we_q, bus_we_d;
  logic          bus_start_q, bus_start_d;
  logic [WW-1:0] wait_q [3];
  logic [WW-1:0] wait_d [3];
  logic [2:0]    req, starving, win_vec;
  logic          fin;
  logic          tmo_hit;
  logic          unused_addr_hi;

  assign req            = {mb.start_c, mb.start_b, mb.start_a};
  assign unused_addr_hi = ^{mb.addr_a[31:27], mb.addr_b[31:27], mb.addr_c[31:27]};

  // Starved requesters outrank the fixed order; lowest index wins among them.
  always_comb begin
    win_vec = '0;
    winner  = GNT_NONE;
    for (int unsigned i = 0; i < 3; i++) begin
      starving[i] = req[i] && (wait_q[i] == WAIT_MAX);
    end
    if      (starving[0]) win_vec = 3'b001;
    else if (starving[1]) win_vec = 3'b010;
    else if (starving[2]) win_vec = 3'b100;
    else if (req[0])      win_vec = 3'b001;
    else if (req[1])      win_vec = 3'b010;
    else if (req[2])      win_vec = 3'b100;
    if      (win_vec[0]) winner = GNT_A;
    else if (win_vec[1]) winner = GNT_B;
    else if (win_vec[2]) winner = GNT_C;
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Held at zero in IDLE so it always starts from zero on entry to BUSY.
  always_comb begin
    tmo_d = '0;
    if (state_q == BUSY) tmo_d = tmo_q + TW'(1);
  end

  assign tmo_hit = (state_q == BUSY) && !mb.bus_done && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    bus_addr_d  = bus_addr_q;
    bus_data_d  = bus_data_q;
    bus_we_d    = bus_we_q;
    bus_start_d = bus_start_q;
    fin         = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner != GNT_NONE) begin
          state_d     = BUSY;
          grant_d     = winner;
          bus_start_d = 1'b1;
          case (winner)
            GNT_A:   begin bus_addr_d = mb.addr_a[26:0]; bus_data_d = mb.data_a; bus_we_d = mb.we_a; end
            GNT_B:   begin bus_addr_d = mb.addr_b[26:0]; bus_data_d = mb.data_b; bus_we_d = mb.we_b; end
            GNT_C:   begin bus_addr_d = mb.addr_c[26:0]; bus_data_d = mb.data_c; bus_we_d = mb.we_c; end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (mb.bus_done || tmo_hit) begin
          fin         = 1'b1;
          state_d     = IDLE;
          grant_d     = GNT_NONE;
          bus_start_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Waiting continues to accrue while another port owns the bus.
    for (int unsigned i = 0; i < 3; i++) begin
      if (!req[i] || (state_q == IDLE && win_vec[i])) wait_d[i] = '0;
      else if (wait_q[i] != WAIT_MAX)                 wait_d[i] = wait_q[i] + WW'(1);
      else                                            wait_d[i] = wait_q[i];
    end
  end

  assign mb.bus_addr    = bus_addr_q;
  assign mb.bus_data    = bus_data_q;
  assign mb.bus_we      = bus_we_q;
  assign mb.bus_start   = (state_q == BUSY) && bus_start_q && !mb.bus_done && !tmo_hit;
  assign mb.done_a      = fin && (grant_q == GNT_A);
  assign mb.done_b      = fin && (grant_q == GNT_B);
  assign mb.done_c      = fin && (grant_q == GNT_C);
  assign mb.q           = tmo_hit ? 32'hDEAD_BEEF : mb.bus_q;
  assign mb.err_timeout = tmo_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_start_q <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) wait_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      bus_we_q    <= bus_we_d;
      bus_start_q <= bus_start_d;
      for (int unsigned i = 0; i < 3; i++) wait_q[i] <= wait_d[i];
    end
  end
endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Scoreboard bench for mem_bus_scheduler: directed requests, bus responder model,
// and a monitor that checks every bus cycle and completion against expectations.
module tb_mem_bus_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_scheduler_if mb();

  mem_bus_scheduler #(
    .STARVE_LIMIT(8)
`ifdef MEM_BUS_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mb   (mb)
  );

  typedef struct {
    int          port;
    logic [26:0] addr;
    logic        we;
    logic [31:0] data;
    logic [31:0] q;
    logic        err;
    int          hi;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cyc = 0;
  logic [31:0] resp_q = '0;
  int          rem_a = 0, rem_b = 0, rem_c = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int port, input logic [26:0] addr, input logic we,
                      input logic [31:0] data, input logic [31:0] q, input logic err, input int hi);
    exp_t e;
    e.port = port; e.addr = addr; e.we = we; e.data = data; e.q = q; e.err = err; e.hi = hi;
    exp_q.push_back(e);
  endtask

  // Bus responder: raises bus_done on the done_cyc-th cycle of bus_start (0 = never).
  initial begin
    int   cnt;
    logic s;
    cnt = 0;
    mb.bus_done = 1'b0;
    mb.bus_q    = '0;
    forever begin
      @(posedge clk);
      #1;
      s = mb.bus_start;
      mb.bus_done = 1'b0;
      if (s && !reset && done_cyc > 0) begin
        cnt++;
        if (cnt == done_cyc) begin
          mb.bus_done = 1'b1;
          mb.bus_q    = resp_q;
          cnt         = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: latched bus fields while bus_start is high, completion contents on done.
  initial begin
    int         hi;
    exp_t       e;
    logic [2:0] dn;
    hi = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi = 0;
        continue;
      end
      if (mb.bus_start) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus_start: got addr %h expected no transaction", mb.bus_addr);
        end else begin
          e = exp_q[0];
          check32("bus_addr", {5'b0, mb.bus_addr}, {5'b0, e.addr});
          check32("bus_we", {31'b0, mb.bus_we}, {31'b0, e.we});
          check32("bus_data", mb.bus_data, e.data);
        end
        hi++;
      end
      dn = {mb.done_c, mb.done_b, mb.done_a};
      if (dn != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %b expected 000", dn);
        end else begin
          e = exp_q.pop_front();
          check32("done_vec", {29'b0, dn}, 32'(1 << e.port));
          check32("q", mb.q, e.q);
          check32("err_timeout", {31'b0, mb.err_timeout}, {31'b0, e.err});
          check32("bus_start_cycles", hi, e.hi);
        end
        hi = 0;
      end else begin
        check32("err_idle", {31'b0, mb.err_timeout}, 32'd0);
      end
    end
  end

  // Advance n cycles; each port drops start after its remaining done count hits zero.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (mb.done_a && rem_a > 0) begin rem_a--; if (rem_a == 0) mb.start_a = 1'b0; end
      if (mb.done_b && rem_b > 0) begin rem_b--; if (rem_b == 0) mb.start_b = 1'b0; end
      if (mb.done_c && rem_c > 0) begin rem_c--; if (rem_c == 0) mb.start_c = 1'b0; end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((mb.start_a || mb.start_b || mb.start_c) && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_bound: got %0d cycles expected < 200", name, n);
    end
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    mb.addr_a = '0; mb.addr_b = '0; mb.addr_c = '0;
    mb.data_a = '0; mb.data_b = '0; mb.data_c = '0;
    mb.we_a = 1'b0; mb.we_b = 1'b0; mb.we_c = 1'b0;
    mb.start_a = 1'b0; mb.start_b = 1'b0; mb.start_c = 1'b0;
    reset = 1'b1;
    cyc(2);
    check32("rst_bus_addr", {5'b0, mb.bus_addr}, 32'd0);
    check32("rst_bus_data", mb.bus_data, 32'd0);
    check32("rst_bus_we", {31'b0, mb.bus_we}, 32'd0);
    check32("rst_bus_start", {31'b0, mb.bus_start}, 32'd0);
    check32("rst_done", {29'b0, mb.done_c, mb.done_b, mb.done_a}, 32'd0);
    check32("rst_err", {31'b0, mb.err_timeout}, 32'd0);
    check32("rst_wait_c", 32'(dut.wait_q[2]), 32'd0);
    reset = 1'b0;
    cyc(1);

    // Single read on port B, bus_done on the 4th BUSY cycle.
    done_cyc = 4; resp_q = 32'h1234_5678;
    mb.addr_b = 32'h0800_0010; mb.data_b = '0; mb.we_b = 1'b0;
    push(1, 27'h000_0010, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3);
    rem_b = 1; mb.start_b = 1'b1;
    cyc(1);
    check32("latency_bus_start", {31'b0, mb.bus_start}, 32'd1);
    wait_idle("single_read");

    // All three ports in the same IDLE cycle.
    done_cyc = 3; resp_q = 32'h0000_00AB;
    mb.addr_a = 32'h0000_1000; mb.data_a = 32'h1111_1111; mb.we_a = 1'b0;
    mb.addr_b = 32'h0000_2000; mb.data_b = 32'h2222_2222; mb.we_b = 1'b0;
    mb.addr_c = 32'h7FFF_3000; mb.data_c = 32'h3333_3333; mb.we_c = 1'b1;
    push(0, 27'h000_1000, 1'b0, 32'h1111_1111, 32'h0000_00AB, 1'b0, 2);
    push(1, 27'h000_2000, 1'b0, 32'h2222_2222, 32'h0000_00AB, 1'b0, 2);
    push(2, 27'h7FF_3000, 1'b1, 32'h3333_3333, 32'h0000_00AB, 1'b0, 2);
    rem_a = 1; rem_b = 1; rem_c = 1;
    mb.start_a = 1'b1; mb.start_b = 1'b1; mb.start_c = 1'b1;
    wait_idle("priority");

    // Starvation: A re-requests continuously, C is promoted once wait_c reaches 8.
    done_cyc = 2; resp_q = 32'hA5A5_0001;
    mb.addr_a = 32'h0000_0A00; mb.data_a = '0; mb.we_a = 1'b0;
    mb.addr_c = 32'h0000_0C00; mb.data_c = '0; mb.we_c = 1'b0;
    push(0, 27'h000_0A00, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 1);
    push(0, 27'h000_0A00, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 1);
    push(0, 27'h000_0A00, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 1);
    push(2, 27'h000_0C00, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 1);
    push(0, 27'h000_0A00, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 1);
    rem_a = 4; rem_c = 1;
    mb.start_a = 1'b1; mb.start_c = 1'b1;
    cyc(9);
    check32("wait_c_saturated", 32'(dut.wait_q[2]), 32'd8);
    cyc(1);
    check32("wait_c_after_grant", 32'(dut.wait_q[2]), 32'd0);
    wait_idle("starvation");

    // Write isolation: requester inputs change while the bus is busy.
    done_cyc = 3; resp_q = 32'h0;
    mb.addr_a = 32'h0000_0100; mb.data_a = 32'hCAFE_BABE; mb.we_a = 1'b1;
    push(0, 27'h000_0100, 1'b1, 32'hCAFE_BABE, 32'h0, 1'b0, 2);
    rem_a = 1; mb.start_a = 1'b1;
    cyc(1);
    mb.data_a = 32'h0; mb.we_a = 1'b0; mb.addr_a = 32'hFFFF_FFFF;
    wait_idle("write_isolation");
    mb.we_a = 1'b0;

    // Reset in the 2nd BUSY cycle of a B transaction while C waits.
    done_cyc = 0;
    mb.addr_b = 32'h0000_0B00; mb.data_b = 32'h0000_00B0; mb.we_b = 1'b0;
    mb.addr_c = 32'h0000_0C00; mb.data_c = 32'h0;         mb.we_c = 1'b0;
    push(1, 27'h000_0B00, 1'b0, 32'h0000_00B0, 32'h0, 1'b0, 0);
    mb.start_b = 1'b1; mb.start_c = 1'b1;
    cyc(1);
    check32("wait_c_busy1", 32'(dut.wait_q[2]), 32'd1);
    cyc(1);
    reset = 1'b1; mb.start_b = 1'b0; mb.start_c = 1'b0;
    cyc(1);
    check32("rstmid_bus_start", {31'b0, mb.bus_start}, 32'd0);
    check32("rstmid_done", {29'b0, mb.done_c, mb.done_b, mb.done_a}, 32'd0);
    check32("rstmid_wait_a", 32'(dut.wait_q[0]), 32'd0);
    check32("rstmid_wait_b", 32'(dut.wait_q[1]), 32'd0);
    check32("rstmid_wait_c", 32'(dut.wait_q[2]), 32'd0);
    cyc(1);
    reset = 1'b0;
    check32("aborted_entries", exp_q.size(), 32'd1);
    void'(exp_q.pop_front());
    done_cyc = 3; resp_q = 32'h0BAD_F00D;
    push(1, 27'h000_0B00, 1'b0, 32'h0000_00B0, 32'h0BAD_F00D, 1'b0, 2);
    rem_b = 1; mb.start_b = 1'b1;
    wait_idle("after_reset");

`ifdef MEM_BUS_TIMEOUT_EN
    // Watchdog abort: bus never answers.
    done_cyc = 0;
    mb.addr_a = 32'h0000_0DE0; mb.data_a = '0; mb.we_a = 1'b0;
    push(0, 27'h000_0DE0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 15);
    rem_a = 1; mb.start_a = 1'b1;
    wait_idle("timeout");
`endif

    check32("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
